// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: takes a byte on a one-cycle strobe and steps the
// TX mux through start, LSB-first data, optional parity and stop phases.
module uart_tx_frame_ctrl #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [1:0]            Mux_Sel,
   output logic                  Ser_Data,
   output logic                  Par_bit,
   output logic                  Busy
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   localparam logic [1:0] SEL_START  = 2'b00;
   localparam logic [1:0] SEL_DATA   = 2'b01;
   localparam logic [1:0] SEL_PARITY = 2'b10;
   localparam logic [1:0] SEL_STOP   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  par_en_q;

   // State sequencing plus outputs decoded from the present state, so the
   // mux select always trails the state register by one clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         shift_q  <= '0;
         bit_cnt  <= '0;
         par_en_q <= 1'b0;
         Par_bit  <= 1'b0;
         Mux_Sel  <= SEL_STOP;
         Ser_Data <= 1'b0;
         Busy     <= 1'b0;
      end else begin
         Busy <= (state != S_IDLE);

         case (state)
            S_IDLE: begin
               Mux_Sel <= SEL_STOP;
               if (Data_Valid) begin
                  shift_q  <= P_DATA;
                  par_en_q <= PAR_EN;
                  Par_bit  <= PAR_TYP ? ~(^P_DATA) : (^P_DATA);
                  state    <= S_START;
               end
            end

            S_START: begin
               Mux_Sel <= SEL_START;
               state   <= S_DATA;
            end

            S_DATA: begin
               Mux_Sel  <= SEL_DATA;
               Ser_Data <= shift_q[0];
               shift_q  <= shift_q >> 1;
               // Counter parks at the last index; STOP returns it to zero.
               if (bit_cnt == CNT_LAST) begin
                  state <= par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            S_PARITY: begin
               Mux_Sel <= SEL_PARITY;
               state   <= S_STOP;
            end

            S_STOP: begin
               Mux_Sel <= SEL_STOP;
               bit_cnt <= '0;
               state   <= S_IDLE;
            end

            default: begin
               Mux_Sel <= SEL_STOP;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl: a frame-level model queues expected
// per-cycle outputs; a negedge monitor compares them against the DUT.
module tb_uart_tx_frame_ctrl;

   localparam int unsigned DW = 8;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  mux;
      logic        ser;
      logic        chk_ser;
      logic        par;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] P_DATA = '0;
   logic          Data_Valid = 1'b1;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [1:0]    Mux_Sel;
   logic          Ser_Data;
   logic          Par_bit;
   logic          Busy;

   int unsigned   cyc = 0;
   int unsigned   next_free = 0;
   int unsigned   checks = 0;
   int unsigned   failures = 0;
   exp_t          exp_q[$];
   exp_t          mon_e;
   exp_t          drop_e;

   uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Mux_Sel    (Mux_Sel),
      .Ser_Data   (Ser_Data),
      .Par_bit    (Par_bit),
      .Busy       (Busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endfunction

   // Frame model: accepted at edge k, the frame appears on the outputs from edge k+1,
   // occupies 2+DW+pe cycles, and the next acceptance is possible one cycle after it.
   function automatic void push_frame(input int unsigned k, input logic [DW-1:0] d,
                                      input logic pe, input logic pt);
      exp_t        e;
      int unsigned len;
      logic        par;
      len = 2 + DW + ((pe) ? 1 : 0);
      par = pt ? ~(^d) : (^d);
      for (int i = 0; i < int'(len); i++) begin
         e.cyc     = k + 1 + i;
         e.par     = par;
         e.ser     = 1'b0;
         e.chk_ser = 1'b0;
         if (i == 0) begin
            e.mux = 2'b00;
         end else if (i <= int'(DW)) begin
            e.mux     = 2'b01;
            e.ser     = d[i-1];
            e.chk_ser = 1'b1;
         end else if (pe && i == int'(DW) + 1) begin
            e.mux = 2'b10;
         end else begin
            e.mux = 2'b11;
         end
         exp_q.push_back(e);
      end
      next_free = k + len + 1;
   endfunction

   // Drive one cycle's inputs shortly after a rising edge; they are sampled at edge k.
   task automatic step(input logic r, input logic dv, input logic [DW-1:0] d,
                       input logic pe, input logic pt);
      int unsigned k;
      @(posedge clk);
      #2;
      rst        = r;
      Data_Valid = dv;
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      k = cyc + 1;
      if (r) begin
         while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= k) drop_e = exp_q.pop_back();
         next_free = k + 1;
      end else if (dv && k >= next_free) begin
         push_frame(k, d, pe, pt);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // Monitor: an expected entry for this cycle must match; otherwise the line is idle.
   always @(negedge clk) begin
      if (cyc != 0) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            chk("missed_frame_cycle", 32'(mon_e.cyc), 32'(cyc));
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            chk("frame_busy", 32'(Busy), 32'd1);
            chk("frame_mux_sel", 32'(Mux_Sel), 32'(mon_e.mux));
            chk("frame_par_bit", 32'(Par_bit), 32'(mon_e.par));
            if (mon_e.chk_ser) chk("frame_ser_data", 32'(Ser_Data), 32'(mon_e.ser));
         end else begin
            chk("idle_busy", 32'(Busy), 32'd0);
            chk("idle_mux_sel", 32'(Mux_Sel), 32'd3);
         end
      end
   end

   initial begin
      int drain;
      // Reset held with Data_Valid asserted: no frame may start afterwards.
      step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
      step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("reset_par_bit", 32'(Par_bit), 32'd0);
      idle(3);

      // Directed frames.
      step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
      idle(14);
      step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
      idle(14);
      step(1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
      idle(14);
      step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
      idle(14);

      // Request during DATA of an A5 frame must be dropped.
      step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
      idle(4);
      step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
      idle(14);

      // Reset in the middle of DATA abandons the frame.
      step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
      idle(5);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(6);

      // Data_Valid held high: frames back-to-back with one idle cycle between.
      for (int i = 0; i < 45; i++) step(1'b0, 1'b1, DW'($urandom), 1'($urandom), 1'($urandom));
      idle(14);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) == 0),
              DW'($urandom), 1'($urandom), 1'($urandom));
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 100) begin
         idle(1);
         drain++;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      idle(3);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
